spi_alu_slave: RTL and testbench

- Parametrised SPI-slave ALU coprocessor.
- The host shifts in a command frame {opcode, A, B} and the block computes one of eight ALU/shift operations, then latches the result and flags.
- The host reads back {carry, zero, result} in a second SPI transaction.
- Generalises the fixed 32-bit shift-only SPI ALU with these additions:
  - configurable WIDTH
  - full operation set
  - proper sclk/nss synchronisation and SPI mode 0 edge handling
  - status flags, frame-error detection, busy/done sideband

---
 rtl/spi_alu_slave.sv | 199 +++++++++++++++++++
 tb/tb_spi_alu_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_alu_slave.sv
// ============================================================================
// Module   : spi_alu_slave
// Purpose  : SPI mode-0 slave ALU coprocessor. It receives {op, A, B},
//            executes one of eight ALU/shift operations and returns
//            {carry, zero, result}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_alu_slave #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic nss,
    input  logic sclk,
    input  logic mosi,
    output logic miso,
    output logic busy,
    output logic done,
    output logic frame_err
);

    localparam int FRAME_IN  = 3 + 2 * WIDTH;
    localparam int FRAME_OUT = WIDTH + 2;
    localparam int CNT_W     = $clog2(FRAME_IN + 1);
    localparam int SH_W      = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_FRAME_IN  = CNT_W'(FRAME_IN);
    localparam logic [CNT_W-1:0] CNT_FRAME_OUT = CNT_W'(FRAME_OUT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RECEIVE = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_READY   = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;

    // Synchronisers reset low so a host still holding nss low across a
    // reset does not produce a spurious falling edge afterwards.
    logic [SYNC_STAGES-1:0] nss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   nss_d;
    logic                   sclk_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nss_sync  <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            nss_d     <= 1'b0;
            sclk_d    <= 1'b0;
        end else begin
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], nss};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            nss_d     <= nss_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic nss_s, sclk_s, mosi_s;
    logic nss_rise, nss_fall, sclk_rise, sclk_fall;

    assign nss_s     = nss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign nss_rise  = nss_s & ~nss_d;
    assign nss_fall  = ~nss_s & nss_d;
    assign sclk_rise = sclk_s & ~sclk_d & ~nss_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~nss_s;

    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [FRAME_IN-1:0]  in_buf;
    logic [FRAME_OUT-1:0] out_sr;
    logic [WIDTH-1:0]     result;
    logic                 carry_flag;
    logic                 zero_flag;

    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic [SH_W-1:0]  sh;
    logic [WIDTH:0]   add_ext, sub_ext, sll_ext, srl_ext, sra_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    assign op = in_buf[FRAME_IN-1 -: 3];
    assign a  = in_buf[2*WIDTH-1 -: WIDTH];
    assign b  = in_buf[WIDTH-1:0];
    assign sh = b[SH_W-1:0];

    // Each extended vector carries the operation's carry/borrow or the
    // last shifted-out bit in its extra position.
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} - {1'b0, b};
    assign sll_ext = {1'b0, a} << sh;
    assign srl_ext = {a, 1'b0} >> sh;
    assign sra_ext = $signed({a, 1'b0}) >>> sh;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            3'b000:  {alu_carry, alu_res} = add_ext;
            3'b001:  {alu_carry, alu_res} = sub_ext;
            3'b010:  alu_res = a & b;
            3'b011:  alu_res = a | b;
            3'b100:  {alu_carry, alu_res} = sll_ext;
            3'b101:  {alu_res, alu_carry} = srl_ext;
            3'b110:  {alu_res, alu_carry} = sra_ext;
            default: alu_res = a ^ b;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            in_buf     <= '0;
            out_sr     <= '0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            miso       <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    miso <= 1'b0;
                    if (nss_fall) begin
                        state     <= S_RECEIVE;
                        cnt       <= '0;
                        frame_err <= 1'b0;
                    end
                end
                S_RECEIVE: begin
                    if (nss_rise) begin
                        if (cnt == CNT_FRAME_IN) begin
                            state <= S_EXEC;
                        end else begin
                            state     <= S_IDLE;
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise && cnt != CNT_FRAME_IN) begin
                        in_buf <= {in_buf[FRAME_IN-2:0], mosi_s};
                        cnt    <= cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    result     <= alu_res;
                    carry_flag <= alu_carry;
                    zero_flag  <= (alu_res == '0);
                    done       <= 1'b1;
                    state      <= S_READY;
                end
                S_READY: begin
                    miso <= 1'b0;
                    if (nss_fall) begin
                        state     <= S_SEND;
                        out_sr    <= {carry_flag, zero_flag, result};
                        miso      <= carry_flag;
                        cnt       <= '0;
                        frame_err <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (nss_rise) begin
                        miso <= 1'b0;
                        if (cnt >= CNT_FRAME_OUT) begin
                            state <= S_IDLE;
                        end else begin
                            state     <= S_READY;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        // Zeros shift in behind the frame, so over-reads return 0.
                        if (sclk_fall) begin
                            out_sr <= {out_sr[FRAME_OUT-2:0], 1'b0};
                            miso   <= out_sr[FRAME_OUT-2];
                        end
                        if (sclk_rise && cnt != CNT_FRAME_OUT) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RECEIVE) || (state == S_EXEC) || (state == S_SEND);

endmodule

`default_nettype wire

// File: tb/tb_spi_alu_slave.sv
// ============================================================================
// Module   : tb_spi_alu_slave
// Purpose  : Scoreboard testbench for spi_alu_slave with a reference ALU model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_alu_slave;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic nss   = 1'b1;
    logic sclk  = 1'b0;
    logic mosi  = 1'b0;
    logic miso, busy, done, frame_err;

    spi_alu_slave #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .nss      (nss),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .busy     (busy),
        .done     (done),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] rd_cap    = '0;
    int          rd_bits   = 0;
    bit          rd_active = 1'b0;
    event        rd_done;
    int          done_cnt  = 0;
    time         done_time = 0;
    time         rise_time = 0;
    logic [33:0] model_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: {carry, zero, result} from the operation definitions.
    function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        c;
        logic [63:0] sum;
        int          s;
        s = int'(b % 32);
        c = 1'b0;
        case (op)
            3'd0: begin sum = 64'(a) + 64'(b); r = sum[31:0]; c = sum[32]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin r = a << s; if (s != 0) c = a[32-s]; end
            3'd5: begin r = a >> s; if (s != 0) c = a[s-1]; end
            3'd6: begin r = $signed(a) >>> s; if (s != 0) c = a[s-1]; end
            default: r = a ^ b;
        endcase
        return {c, (r == 32'd0), r};
    endfunction

    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_time = $time;
        end
    end

    always @(posedge sclk) begin
        if (rd_active) begin
            rd_cap = {rd_cap[62:0], miso};
            rd_bits++;
        end
    end

    initial begin
        forever begin
            @(rd_done);
            if (exp_q.size() == 0) check("unexpected_readback", rd_cap, 64'hDEAD);
            else check("readback", rd_cap, exp_q.pop_front());
        end
    end

    task automatic hp();
        repeat (6) @(negedge clock);
    endtask

    task automatic spi_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int nbits, input bit raise);
        logic [66:0] fr;
        fr = {op, a, b};
        @(negedge clock);
        nss = 1'b0;
        hp();
        for (int i = 0; i < nbits; i++) begin
            mosi = fr[66-i];
            hp();
            sclk = 1'b1;
            hp();
            sclk = 1'b0;
            if (i == 0) check("busy_receive", busy, 1);
        end
        hp();
        if (raise) begin
            nss = 1'b1;
            rise_time = $time;
            repeat (10) @(negedge clock);
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int d0;
        d0 = done_cnt;
        spi_cmd(op, a, b, 67, 1'b1);
        model_res = model(op, a, b);
        check("done_pulse", 64'(done_cnt - d0), 1);
        check("done_latency", 64'(done_time - rise_time), 40);
        check("ferr_after_cmd", frame_err, 0);
        check("busy_ready", busy, 0);
        check("miso_ready", miso, 0);
    endtask

    task automatic spi_read(input int nbits, input bit full);
        @(negedge clock);
        nss = 1'b0;
        if (full) exp_q.push_back(64'(model_res) << (nbits - 34));
        hp();
        rd_cap    = '0;
        rd_bits   = 0;
        rd_active = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            hp();
            sclk = 1'b1;
            hp();
            sclk = 1'b0;
        end
        hp();
        rd_active = 1'b0;
        nss = 1'b1;
        if (full) ->rd_done;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clock);
        check("reset_outputs", {miso, busy, done, frame_err}, 4'b0000);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        do_cmd(3'd0, 32'h0000_0005, 32'hFFFF_FFFF);
        check("model_add", model_res, {1'b1, 1'b0, 32'h0000_0004});
        spi_read(34, 1'b1);
        do_cmd(3'd1, 32'd5, 32'd5);
        spi_read(34, 1'b1);
        do_cmd(3'd1, 32'd3, 32'd5);
        spi_read(34, 1'b1);
        do_cmd(3'd6, 32'h8000_0000, 32'd4);
        spi_read(34, 1'b1);
        do_cmd(3'd4, 32'h8000_0001, 32'd33);
        spi_read(36, 1'b1);

        // Short command frame: error, no done, result retained, back in IDLE.
        d0 = done_cnt;
        spi_cmd(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 40, 1'b1);
        check("abort_cmd_ferr", frame_err, 1);
        check("abort_cmd_nodone", 64'(done_cnt - d0), 0);
        check("abort_cmd_busy", busy, 0);
        do_cmd(3'd7, 32'hFFFF_0000, 32'h0F0F_0F0F);
        spi_read(34, 1'b1);

        // Short readback: error, stays READY so the retry returns the result.
        do_cmd(3'd0, 32'd1, 32'd1);
        spi_read(10, 1'b0);
        check("abort_rd_ferr", frame_err, 1);
        check("abort_rd_busy", busy, 0);
        spi_read(34, 1'b1);
        check("retry_rd_ferr", frame_err, 0);

        // Reset in the middle of a command frame.
        spi_cmd(3'd3, 32'h0000_00F0, 32'h0000_0F00, 20, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_outputs", {miso, busy, done, frame_err}, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        nss = 1'b1;
        repeat (10) @(negedge clock);
        check("postreset_outputs", {miso, busy, done, frame_err}, 4'b0000);
        do_cmd(3'd3, 32'h0000_00F0, 32'h0000_0F00);
        spi_read(34, 1'b1);

        for (int k = 0; k < 16; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (k % 4 == 0) ra = 32'd0;
            do_cmd(rop, ra, rb);
            spi_read(34, 1'b1);
        end

        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
